// File: rtl/prio_arbiter_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter_n_if
//  Description : Request/grant bundle between the requesters and the priority
//                arbiter. The requester side drives req and observes the
//                grant; the arbiter side does the reverse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prio_arbiter_n_if #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) ();
  logic [N-1:0]    req;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic [N-1:0]    gnt_onehot;
  logic            any_req;

  modport master (output req, input gnt_valid, gnt_idx, gnt_onehot, any_req);
  modport slave  (input req, output gnt_valid, gnt_idx, gnt_onehot, any_req);
endinterface
`default_nettype wire

// File: rtl/prio_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter_n
//  Description : Registered N-way priority arbiter. Fixed (highest index
//                wins) or round-robin order, grant held while the owner keeps
//                requesting, optional maximum-hold forced rotation.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter_n #(
  parameter int N        = 8,
  parameter int IDXW     = $clog2(N),
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 0,
  parameter int CNTW     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  prio_arbiter_n_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;
  logic            any_req_q, any_req_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [IDXW-1:0] start_idx;
  logic [N-1:0]    others;
  logic [IDXW-1:0] win_all;
  logic [IDXW-1:0] win_oth;
  logic            holder_req;
  logic            timeout;

  // First set bit of m scanning downward from start, wrapping 0 -> N-1.
  function automatic logic [IDXW-1:0] pick(input logic [N-1:0] m,
                                           input logic [IDXW-1:0] start);
    logic [IDXW-1:0] w;
    logic [IDXW-1:0] ii;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) - k;
      if (idx < 0) idx = idx + N;
      ii = IDXW'(idx);
      if (!found && m[ii]) begin
        w     = ii;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Scan origin: top index in fixed mode, one below the last winner in RR.
  always_comb begin
    start_idx = IDXW'(N - 1);
    if (RR_MODE != 0 && last_q != '0) start_idx = last_q - 1'b1;
  end

  // Candidate winners; the holder is masked out for release/rotation.
  always_comb begin
    others     = bus.req & ~gnt_onehot_q;
    holder_req = bus.req[gnt_idx_q];
    timeout    = (MAX_HOLD > 0) && (cnt_q == CNTW'(MAX_HOLD));
    win_all    = pick(bus.req, start_idx);
    win_oth    = pick(others, start_idx);
  end

  // Next-state: arbitrate from idle, hold / release / forced rotation in grant.
  always_comb begin
    state_d      = state_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    any_req_d    = |bus.req;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d      = GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = win_all;
          gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_all;
          last_d       = win_all;
          cnt_d        = CNTW'(1);
        end
      end
      GRANT: begin
        // Release takes precedence over timeout; both hand over to win_oth.
        if ((!holder_req || timeout) && (|others)) begin
          gnt_idx_d    = win_oth;
          gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_oth;
          last_d       = win_oth;
          cnt_d        = CNTW'(1);
        end else if (!holder_req) begin
          state_d      = IDLE;
          gnt_valid_d  = 1'b0;
          gnt_idx_d    = '0;
          gnt_onehot_d = '0;
          cnt_d        = '0;
        end else if (MAX_HOLD > 0 && cnt_q != CNTW'(MAX_HOLD)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        gnt_valid_d  = 1'b0;
        gnt_idx_d    = '0;
        gnt_onehot_d = '0;
        cnt_d        = '0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      any_req_q    <= 1'b0;
      last_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      any_req_q    <= any_req_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.any_req    = any_req_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_arbiter_n
//  Description : Directed bench for prio_arbiter_n: fixed priority, round
//                robin (N=8 and N=5), hold lock, max-hold rotation, resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter_n;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  prio_arbiter_n_if #(.N(8)) if_fix ();
  prio_arbiter_n_if #(.N(8)) if_rr  ();
  prio_arbiter_n_if #(.N(8)) if_to  ();
  prio_arbiter_n_if #(.N(5)) if_r5  ();

  prio_arbiter_n #(.N(8), .RR_MODE(0), .MAX_HOLD(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(if_fix));
  prio_arbiter_n #(.N(8), .RR_MODE(1), .MAX_HOLD(0)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(if_rr));
  prio_arbiter_n #(.N(8), .RR_MODE(0), .MAX_HOLD(4)) u_to  (.clk(clk), .rst_n(rst_n), .bus(if_to));
  prio_arbiter_n #(.N(5), .RR_MODE(1), .MAX_HOLD(0)) u_r5  (.clk(clk), .rst_n(rst_n), .bus(if_r5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       ev;
    logic [2:0] ei;
    logic [7:0] eo;
  } vec_t;

  vec_t fix_tab [11];

  function automatic logic [7:0] oh8(input logic v, input logic [2:0] i);
    logic [7:0] one;
    one = 8'h01;
    return v ? (one << i) : 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm,
                       input logic av, input logic [2:0] ai, input logic [7:0] ao, input logic aa,
                       input logic ev, input logic [2:0] ei, input logic [7:0] eo, input logic ea);
    n_vec++;
    if ({av, ai, ao, aa} !== {ev, ei, eo, ea}) begin
      n_err++;
      $display("FAIL %s: got v=%0b idx=%0d oh=%02h any=%0b, want v=%0b idx=%0d oh=%02h any=%0b",
               nm, av, ai, ao, aa, ev, ei, eo, ea);
    end
  endtask

  task automatic chk_fix(input string nm, input logic ev, input logic [2:0] ei, input logic [7:0] eo, input logic ea);
    check(nm, if_fix.gnt_valid, if_fix.gnt_idx, if_fix.gnt_onehot, if_fix.any_req, ev, ei, eo, ea);
  endtask
  task automatic chk_rr(input string nm, input logic ev, input logic [2:0] ei, input logic [7:0] eo, input logic ea);
    check(nm, if_rr.gnt_valid, if_rr.gnt_idx, if_rr.gnt_onehot, if_rr.any_req, ev, ei, eo, ea);
  endtask
  task automatic chk_to(input string nm, input logic ev, input logic [2:0] ei, input logic [7:0] eo, input logic ea);
    check(nm, if_to.gnt_valid, if_to.gnt_idx, if_to.gnt_onehot, if_to.any_req, ev, ei, eo, ea);
  endtask
  task automatic chk_r5(input string nm, input logic ev, input logic [2:0] ei, input logic [7:0] eo, input logic ea);
    check(nm, if_r5.gnt_valid, if_r5.gnt_idx, {3'b000, if_r5.gnt_onehot}, if_r5.any_req, ev, ei, eo, ea);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] h;
    logic [7:0] one;
    one   = 8'h01;
    n_vec = 0;
    n_err = 0;

    // Fixed-priority vectors: req applied, expected grant after next edge.
    fix_tab[0]  = '{8'b0010_1001, 1'b1, 3'd5, 8'h20};
    fix_tab[1]  = '{8'b0000_1001, 1'b1, 3'd3, 8'h08};
    fix_tab[2]  = '{8'b0000_0001, 1'b1, 3'd0, 8'h01};
    fix_tab[3]  = '{8'h00,        1'b0, 3'd0, 8'h00};
    fix_tab[4]  = '{8'h00,        1'b0, 3'd0, 8'h00};
    fix_tab[5]  = '{8'h84,        1'b1, 3'd7, 8'h80};
    fix_tab[6]  = '{8'h84,        1'b1, 3'd7, 8'h80};
    fix_tab[7]  = '{8'h04,        1'b1, 3'd2, 8'h04};
    fix_tab[8]  = '{8'h06,        1'b1, 3'd2, 8'h04};
    fix_tab[9]  = '{8'h02,        1'b1, 3'd1, 8'h02};
    fix_tab[10] = '{8'h00,        1'b0, 3'd0, 8'h00};

    // Reset held with every request asserted.
    rst_n = 1'b0;
    if_fix.req = 8'hFF; if_rr.req = 8'hFF; if_to.req = 8'hFF; if_r5.req = 5'h1F;
    step(); step();
    chk_fix("reset_fix", 1'b0, 3'd0, 8'h00, 1'b0);
    chk_rr ("reset_rr",  1'b0, 3'd0, 8'h00, 1'b0);
    chk_to ("reset_to",  1'b0, 3'd0, 8'h00, 1'b0);
    chk_r5 ("reset_r5",  1'b0, 3'd0, 8'h00, 1'b0);

    if_fix.req = 8'h00; if_rr.req = 8'h00; if_to.req = 8'h00; if_r5.req = 5'h00;
    rst_n = 1'b1;
    step();
    chk_fix("idle_after_reset", 1'b0, 3'd0, 8'h00, 1'b0);

    // Fixed-priority table.
    for (int i = 0; i < 11; i++) begin
      if_fix.req = fix_tab[i].req;
      step();
      chk_fix($sformatf("fix_vec%0d", i), fix_tab[i].ev, fix_tab[i].ei, fix_tab[i].eo, |fix_tab[i].req);
    end

    // Hold lock: holder 2 keeps requesting, 7 waits forever without timeout.
    if_fix.req = 8'h04;
    step();
    chk_fix("lock_start", 1'b1, 3'd2, 8'h04, 1'b1);
    if_fix.req = 8'h84;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_fix($sformatf("lock_hold%0d", i), 1'b1, 3'd2, 8'h04, 1'b1);
    end
    if_fix.req = 8'h00;
    step();
    chk_fix("lock_end", 1'b0, 3'd0, 8'h00, 1'b0);

    // Round robin N=8: holder drops for one cycle, next in line takes over.
    if_rr.req = 8'hFF;
    step();
    h = 3'd7;
    chk_rr("rr_first", 1'b1, h, oh8(1'b1, h), 1'b1);
    for (int i = 0; i < 8; i++) begin
      if_rr.req = 8'hFF & ~(one << h);
      step();
      h = h - 3'd1;
      chk_rr($sformatf("rr_seq%0d", i), 1'b1, h, oh8(1'b1, h), 1'b1);
    end
    if_rr.req = 8'h00;
    step();
    chk_rr("rr_idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // Round robin N=5: wrap is modulo 5, so 0 is followed by 4.
    if_r5.req = 5'h1F;
    step();
    h = 3'd4;
    chk_r5("r5_first", 1'b1, h, oh8(1'b1, h), 1'b1);
    for (int i = 0; i < 5; i++) begin
      if_r5.req = 5'h1F & ~(5'h01 << h);
      step();
      h = (h == 3'd0) ? 3'd4 : h - 3'd1;
      chk_r5($sformatf("r5_seq%0d", i), 1'b1, h, oh8(1'b1, h), 1'b1);
    end
    if_r5.req = 5'h00;
    step();
    chk_r5("r5_idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // Max-hold 4: grant 2, then 7 arrives; 2 is visible for 4 cycles total.
    if_to.req = 8'h04;
    step();
    chk_to("to_g2_c1", 1'b1, 3'd2, 8'h04, 1'b1);
    if_to.req = 8'h84;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_to($sformatf("to_g2_c%0d", i), 1'b1, 3'd2, 8'h04, 1'b1);
    end
    step();
    chk_to("to_rot_to7", 1'b1, 3'd7, 8'h80, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_to($sformatf("to_g7_c%0d", i), 1'b1, 3'd7, 8'h80, 1'b1);
    end
    step();
    chk_to("to_rot_to2", 1'b1, 3'd2, 8'h04, 1'b1);
    // Only the holder requests: no rotation past the limit.
    if_to.req = 8'h04;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_to($sformatf("to_alone%0d", i), 1'b1, 3'd2, 8'h04, 1'b1);
    end
    if_to.req = 8'h00;
    step();
    chk_to("to_idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // Async reset mid-grant in RR mode; pointer must restart at the top.
    if_rr.req = 8'h20;
    step();
    chk_rr("ar_g5", 1'b1, 3'd5, 8'h20, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_rr("ar_drop", 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    if_rr.req = 8'h28;
    rst_n = 1'b1;
    step();
    chk_rr("ar_regrant", 1'b1, 3'd5, 8'h20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
